// File: rtl/ascii_pkg.sv
// Shared constants and types for the word-to-ASCII serialiser.
package ascii_pkg;

  localparam logic [7:0] CH_NUL        = 8'h00;
  localparam logic [7:0] CH_0          = 8'h30;
  localparam logic [7:0] CH_1          = 8'h31;
  localparam logic [7:0] CH_A          = 8'h41;
  localparam logic [7:0] CH_B_LOWER    = 8'h62;
  localparam logic [7:0] CH_X_LOWER    = 8'h78;
  localparam logic [7:0] CH_UNDERSCORE = 8'h5F;

  typedef enum logic {
    MODE_BIN = 1'b0,
    MODE_HEX = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Number of characters rendered for one word in the given mode.
  function automatic int char_count(input int width, input int prefix_en,
                                    input int sep_en, input bit hex);
    if (hex)
      return 2 * prefix_en + width / 4;
    else
      return 2 * prefix_en + width + sep_en * (width / 4 - 1);
  endfunction

endpackage

// File: rtl/word_to_ascii_stream_if.sv
// Word-in / character-out handshake bundle for word_to_ascii_stream.
interface word_to_ascii_stream_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_last;

  // Producer of words and consumer of characters.
  modport master (
    output in_valid, in_word, in_mode, out_ready,
    input  in_ready, out_valid, out_char, out_last
  );

  // The serialiser itself.
  modport slave (
    input  in_valid, in_word, in_mode, out_ready,
    output in_ready, out_valid, out_char, out_last
  );

endinterface

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase hex ASCII digit.
module nibble_to_ascii
  import ascii_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ch
);

  // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'.
  always_comb begin
    if (nibble < 4'd10)
      ch = CH_0 + {4'h0, nibble};
    else
      ch = CH_A + ({4'h0, nibble} - 8'd10);
  end

endmodule

// File: rtl/word_to_ascii_stream.sv
// Serialises a latched word into ASCII binary or hex digits, MSB first,
// with optional "0b"/"0x" prefix and optional '_' nibble separators.
//
// state | meaning
// IDLE  | ready for a new word, no character presented
// EMIT  | presenting char[idx_q] of the latched word
module word_to_ascii_stream
  import ascii_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int PREFIX_EN = 1,
  parameter int SEP_EN    = 1
) (
  input logic             clk,
  input logic             reset_n,
  word_to_ascii_stream_if.slave bus
);

  localparam int HEX_CNT = char_count(WIDTH, PREFIX_EN, SEP_EN, 1'b1);
  localparam int BIN_CNT = char_count(WIDTH, PREFIX_EN, SEP_EN, 1'b0);
  localparam int MAX_CNT = (HEX_CNT > BIN_CNT) ? HEX_CNT : BIN_CNT;
  localparam int IDX_W   = $clog2(MAX_CNT + 1);
  localparam int DIG_W   = $clog2(WIDTH);

  localparam logic [IDX_W-1:0] HEX_LAST = IDX_W'(HEX_CNT - 1);
  localparam logic [IDX_W-1:0] BIN_LAST = IDX_W'(BIN_CNT - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  word_q, word_d;
  mode_e             mode_q, mode_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  // dig_q: digit position counted from the MSB; nib_pos_q: bit within the
  // current nibble; sep_q: the current character is a '_' separator.
  logic [DIG_W-1:0]  dig_q, dig_d;
  logic [1:0]        nib_pos_q, nib_pos_d;
  logic              sep_q, sep_d;

  logic [3:0]        hex_nib;
  logic [7:0]        hex_ch;
  logic              bin_bit;
  logic              in_prefix;
  logic [IDX_W-1:0]  last_idx;
  logic              idle_ready;

  // Select the digit currently addressed from the latched word.
  always_comb begin
    hex_nib = 4'h0;
    bin_bit = 1'b0;
    for (int i = 0; i < WIDTH / 4; i++)
      if (dig_q == DIG_W'(i)) hex_nib = word_q[WIDTH-1-4*i -: 4];
    for (int i = 0; i < WIDTH; i++)
      if (dig_q == DIG_W'(i)) bin_bit = word_q[WIDTH-1-i];
  end

  nibble_to_ascii u_nib (
    .nibble (hex_nib),
    .ch     (hex_ch)
  );

  assign in_prefix = (PREFIX_EN != 0) && (idx_q < IDX_W'(2));
  assign last_idx  = (mode_q == MODE_HEX) ? HEX_LAST : BIN_LAST;
  // Reset must hold in_ready low even though the state register sits in IDLE.
  assign bus.in_ready = idle_ready & reset_n;

  // Next-state, counters and decoded outputs.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    mode_d        = mode_q;
    idx_d         = idx_q;
    dig_d         = dig_q;
    nib_pos_d     = nib_pos_q;
    sep_d         = sep_q;
    idle_ready    = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_char  = CH_NUL;
    bus.out_last  = 1'b0;

    case (state_q)
      IDLE: begin
        idle_ready = 1'b1;
        if (bus.in_valid) begin
          word_d    = bus.in_word;
          mode_d    = mode_e'(bus.in_mode);
          idx_d     = '0;
          dig_d     = '0;
          nib_pos_d = '0;
          sep_d     = 1'b0;
          state_d   = EMIT;
        end
      end

      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (idx_q == last_idx);
        if (in_prefix)
          bus.out_char = (idx_q == '0) ? CH_0 :
                         (mode_q == MODE_HEX) ? CH_X_LOWER : CH_B_LOWER;
        else if (sep_q)
          bus.out_char = CH_UNDERSCORE;
        else if (mode_q == MODE_HEX)
          bus.out_char = hex_ch;
        else
          bus.out_char = bin_bit ? CH_1 : CH_0;

        if (bus.out_ready) begin
          if (idx_q == last_idx) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (!in_prefix) begin
              if (sep_q) begin
                sep_d = 1'b0;
              end else begin
                dig_d = dig_q + 1'b1;
                if (mode_q == MODE_BIN) begin
                  nib_pos_d = nib_pos_q + 1'b1;
                  // The final bit ends the word before a trailing '_' can appear.
                  if ((SEP_EN != 0) && (nib_pos_q == 2'd3)) sep_d = 1'b1;
                end
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      mode_q    <= MODE_BIN;
      idx_q     <= '0;
      dig_q     <= '0;
      nib_pos_q <= '0;
      sep_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      dig_q     <= dig_d;
      nib_pos_q <= nib_pos_d;
      sep_q     <= sep_d;
    end
  end

endmodule
